// File: rtl/logic_unit_pipe.sv
// Two-stage registered logic-op slice: applies one of eight gate functions to two
// operands (bitwise or as a reduction of a_in) with valid/ready flow control.
module logic_unit_pipe #(
    parameter int WIDTH   = 8,
    parameter int COUNT_W = 16
) (
    input  logic               clk_in,
    input  logic               rst_n_in,
    input  logic [WIDTH-1:0]   a_in,
    input  logic [WIDTH-1:0]   b_in,
    input  logic [2:0]         op_in,
    input  logic               mode_in,
    input  logic               valid_in,
    output logic               ready_out,
    output logic [WIDTH-1:0]   result_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic [COUNT_W-1:0] op_count_out
);

    localparam logic [2:0] OP_NOT  = 3'd0;
    localparam logic [2:0] OP_BUF  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_NAND = 3'd4;
    localparam logic [2:0] OP_NOR  = 3'd5;
    localparam logic [2:0] OP_XOR  = 3'd6;
    localparam logic [2:0] OP_XNOR = 3'd7;

    // Handshakes: a beat moves when the sender's valid and the receiver's ready are
    // both high at a rising edge; valid never waits on ready, and a held beat stays put.
    logic               s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0]   s1_a_q, s1_a_d;
    logic [WIDTH-1:0]   s1_b_q, s1_b_d;
    logic [2:0]         s1_op_q, s1_op_d;
    logic               s1_mode_q, s1_mode_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [COUNT_W-1:0] count_q, count_d;

    logic               s2_free;
    logic [WIDTH-1:0]   bitwise_r;
    logic               reduce_bit;
    logic [WIDTH-1:0]   func_r;

    always_comb begin
        bitwise_r  = '0;
        reduce_bit = 1'b0;
        case (s1_op_q)
            OP_NOT:  begin bitwise_r = ~s1_a_q;            reduce_bit = ~s1_a_q[0]; end
            OP_BUF:  begin bitwise_r = s1_a_q;             reduce_bit = s1_a_q[0];  end
            OP_AND:  begin bitwise_r = s1_a_q & s1_b_q;    reduce_bit = &s1_a_q;    end
            OP_OR:   begin bitwise_r = s1_a_q | s1_b_q;    reduce_bit = |s1_a_q;    end
            OP_NAND: begin bitwise_r = ~(s1_a_q & s1_b_q); reduce_bit = ~&s1_a_q;   end
            OP_NOR:  begin bitwise_r = ~(s1_a_q | s1_b_q); reduce_bit = ~|s1_a_q;   end
            OP_XOR:  begin bitwise_r = s1_a_q ^ s1_b_q;    reduce_bit = ^s1_a_q;    end
            OP_XNOR: begin bitwise_r = ~(s1_a_q ^ s1_b_q); reduce_bit = ~^s1_a_q;   end
        endcase
        func_r = s1_mode_q ? {{(WIDTH-1){1'b0}}, reduce_bit} : bitwise_r;
    end

    always_comb begin
        s2_free   = !valid_q || ready_in;
        ready_out = !s1_valid_q || s2_free;

        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_mode_d  = s1_mode_q;
        if (ready_out) begin
            s1_valid_d = valid_in;
            if (valid_in) begin
                s1_a_d    = a_in;
                s1_b_d    = b_in;
                s1_op_d   = op_in;
                s1_mode_d = mode_in;
            end
        end

        // Result register only changes on a real load so it holds through idle gaps.
        valid_d  = valid_q;
        result_d = result_q;
        if (s2_free) begin
            valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d = func_r;
            end
        end

        count_d = count_q;
        if (valid_q && ready_in) begin
            count_d = count_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_op_q    <= '0;
            s1_mode_q  <= 1'b0;
            valid_q    <= 1'b0;
            result_q   <= '0;
            count_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_op_q    <= s1_op_d;
            s1_mode_q  <= s1_mode_d;
            valid_q    <= valid_d;
            result_q   <= result_d;
            count_q    <= count_d;
        end
    end

    assign result_out   = result_q;
    assign valid_out    = valid_q;
    assign op_count_out = count_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: directed and random streams checked against a truth-table
// and popcount reference model, with an in-order expected queue and handshake counter.
module tb_logic_unit_pipe;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a, b;
    logic [2:0]   op;
    logic         mode, vin, rin;
    logic         rdy, rdy4, vout, vout4;
    logic [W-1:0] res, res4;
    logic [15:0]  cnt;
    logic [3:0]   cnt4;

    logic [W-1:0] exp_q[$];
    logic [3:0]   tt[8];
    int           total = 0;
    int           bad = 0;
    int           count_model = 0;

    logic_unit_pipe #(.WIDTH(W), .COUNT_W(16)) dut (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op), .mode_in(mode),
        .valid_in(vin), .ready_out(rdy), .result_out(res), .valid_out(vout),
        .ready_in(rin), .op_count_out(cnt)
    );

    logic_unit_pipe #(.WIDTH(W), .COUNT_W(4)) dut4 (
        .clk_in(clk), .rst_n_in(rst_n), .a_in(a), .b_in(b), .op_in(op), .mode_in(mode),
        .valid_in(vin), .ready_out(rdy4), .result_out(res4), .valid_out(vout4),
        .ready_in(rin), .op_count_out(cnt4)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // reference: per-bit truth table lookup, reductions from the popcount of a
    function automatic logic [W-1:0] ref_fn(input logic [W-1:0] fa, input logic [W-1:0] fb,
                                            input logic [2:0] fop, input logic fmode);
        logic [W-1:0] r;
        int ones;
        logic bit_r;
        r = '0;
        if (!fmode) begin
            for (int i = 0; i < W; i++) r[i] = tt[fop][{fa[i], fb[i]}];
        end else begin
            ones = $countones(fa);
            case (fop)
                3'd0: bit_r = !fa[0];
                3'd1: bit_r = fa[0];
                3'd2: bit_r = (ones == W);
                3'd3: bit_r = (ones != 0);
                3'd4: bit_r = (ones != W);
                3'd5: bit_r = (ones == 0);
                3'd6: bit_r = (ones % 2 == 1);
                default: bit_r = (ones % 2 == 0);
            endcase
            r[0] = bit_r;
        end
        return r;
    endfunction

    // driver: called at posedge+1, returns at the next posedge+1
    task automatic drive_cycle(input logic dv, input logic [W-1:0] da, input logic [W-1:0] db,
                               input logic [2:0] dop, input logic dmode, input logic drin,
                               output logic in_hs);
        logic [W-1:0] e;
        vin = dv; a = da; b = db; op = dop; mode = dmode; rin = drin;
        #3;
        in_hs = vin && rdy;
        if (vout && rin) begin
            chk("sb_expected_present", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("sb_result", 32'(res), 32'(e));
                chk("sb_result_c4", 32'(res4), 32'(e));
            end
            count_model++;
        end
        if (in_hs) exp_q.push_back(ref_fn(da, db, dop, dmode));
        @(posedge clk);
        #1;
        chk("op_count", 32'(cnt), 32'(count_model % 65536));
        chk("op_count_c4", 32'(cnt4), 32'(count_model % 16));
    endtask

    task automatic drain(input int max_cycles);
        logic hs;
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cycles) begin
            drive_cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, hs);
            n++;
        end
        chk("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #7;
        rst_n = 1'b1;
        exp_q.delete();
        count_model = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic hs;
        int idx, cyc, acc;
        logic [W-1:0] red_exp[6];
        logic [2:0]   red_ops[6];
        tt = '{4'b0011, 4'b1100, 4'b1000, 4'b1110, 4'b0111, 4'b0001, 4'b0110, 4'b1001};
        vin = 0; a = '0; b = '0; op = '0; mode = 0; rin = 0;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        chk("reset_valid_out", 32'(vout), 32'd0);
        chk("reset_result", 32'(res), 32'd0);
        chk("reset_count", 32'(cnt), 32'd0);
        chk("reset_ready_out", 32'(rdy), 32'd1);

        // bitwise, all ops back to back; literal expectations checked via queue
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 8'hA5, 8'h0F, 3'(i), 1'b0, 1'b1, hs);
            chk("bw_accept", 32'(hs), 32'd1);
            if (i == 0) chk("bw_latency_lo", 32'(vout), 32'd0);
            if (i == 1) chk("bw_latency_hi", 32'(vout), 32'd1);
        end
        chk("bw_throughput_count", 32'(cnt), 32'd6);
        begin
            logic [W-1:0] lit[8];
            lit = '{8'h5A, 8'hA5, 8'h05, 8'hAF, 8'hFA, 8'h50, 8'hAA, 8'h55};
            chk("bw_lit_q6", 32'(exp_q[0]), 32'(lit[6]));
            chk("bw_lit_q7", 32'(exp_q[1]), 32'(lit[7]));
        end
        drain(10);
        chk("bw_count_8", 32'(cnt), 32'd8);

        // reduction mode with literal expectations
        red_ops = '{3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5};
        red_exp = '{8'h00, 8'h01, 8'h00, 8'h01, 8'h01, 8'h00};
        for (int i = 0; i < 6; i++) begin
            drive_cycle(1'b1, 8'hA5, 8'h33, red_ops[i], 1'b1, 1'b1, hs);
            chk("red_lit", 32'(ref_fn(8'hA5, 8'h33, red_ops[i], 1'b1)), 32'(red_exp[i]));
        end
        drive_cycle(1'b1, 8'hFF, 8'h00, 3'd2, 1'b1, 1'b1, hs);
        drain(10);

        // backpressure: ready_in low for 5 cycles
        idx = 0; acc = 0; cyc = 0;
        while ((idx < 4 || exp_q.size() != 0) && cyc < 40) begin
            drive_cycle(idx < 4, 8'hFF, 8'(idx + 1), 3'd2, 1'b0, cyc >= 5, hs);
            if (hs) idx++;
            if (cyc == 1) chk("bp_two_accepts", 32'(idx), 32'd2);
            if (cyc >= 2 && cyc <= 4) begin
                chk("bp_ready_low", 32'(rdy), 32'd0);
                chk("bp_hold_valid", 32'(vout), 32'd1);
                chk("bp_hold_result", 32'(res), 32'h01);
            end
            cyc++;
        end
        chk("bp_done", 32'(idx), 32'd4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // random traffic
        acc = 0; cyc = 0;
        while (acc < 1000 && cyc < 20000) begin
            drive_cycle($urandom_range(0, 9) < 7, W'($urandom), W'($urandom),
                        3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 9) < 7, hs);
            if (hs) acc++;
            cyc++;
        end
        chk("rand_accepted", 32'(acc), 32'd1000);
        drain(20);

        // async reset between edges with both stages full and stalled
        drive_cycle(1'b1, 8'h11, 8'h22, 3'd6, 1'b0, 1'b0, hs);
        drive_cycle(1'b1, 8'h33, 8'h44, 3'd3, 1'b0, 1'b0, hs);
        vin = 1'b0;
        chk("ar_full_stall", 32'(rdy), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid_out", 32'(vout), 32'd0);
        chk("ar_count", 32'(cnt), 32'd0);
        chk("ar_ready", 32'(rdy), 32'd1);
        exp_q.delete();
        count_model = 0;
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ar_ready_release", 32'(rdy), 32'd1);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, '0, '0, 3'd0, 1'b0, 1'b1, hs);
        chk("ar_no_ghost", 32'(vout), 32'd0);

        // 17 results on a 4-bit counter
        do_reset();
        for (int i = 0; i < 17; i++) drive_cycle(1'b1, W'($urandom), W'($urandom), 3'(i % 8), 1'b0, 1'b1, hs);
        drain(10);
        chk("wrap_c4", 32'(cnt4), 32'h1);
        chk("wrap_c16", 32'(cnt), 32'd17);
        drive_cycle(1'b1, 8'h0F, 8'hF0, 3'd3, 1'b0, 1'b1, hs);
        drain(10);
        chk("wrap_c4_next", 32'(cnt4), 32'h2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

endmodule
